// File: rtl/csi2tx_dphy_lp_rx_lane_mon_if.sv
// LP line inputs and PPI status outputs for a set of D-PHY lanes.
// The PHY/line side drives through master; the lane monitor sits on slave.
interface csi2tx_dphy_lp_rx_lane_mon_if #(
  parameter int NUM_LANES = 4
);
  logic [NUM_LANES-1:0] lp_rx_cp;
  logic [NUM_LANES-1:0] lp_rx_cn;
  logic [NUM_LANES-1:0] stopstate;
  logic [NUM_LANES-1:0] rxulpsnot;
  logic [NUM_LANES-1:0] ulpsactivenot;
  logic [NUM_LANES-1:0] rxactivehs;
  logic [NUM_LANES-1:0] sot;
  logic [NUM_LANES-1:0] hs_rx_cntrl;
  logic [NUM_LANES-1:0] lp_rx_cntrl;
  logic [NUM_LANES-1:0] lp_seq_err;

  modport master (
    output lp_rx_cp, lp_rx_cn,
    input  stopstate, rxulpsnot, ulpsactivenot, rxactivehs, sot,
           hs_rx_cntrl, lp_rx_cntrl, lp_seq_err
  );

  modport slave (
    input  lp_rx_cp, lp_rx_cn,
    output stopstate, rxulpsnot, ulpsactivenot, rxactivehs, sot,
           hs_rx_cntrl, lp_rx_cntrl, lp_seq_err
  );
endinterface

// File: rtl/csi2tx_dphy_lp_rx_lane_mon.sv
// Per-lane LP line-state receiver: synchroniser, glitch filter and LP sequence FSM
// producing PPI status, transceiver enables and illegal-sequence pulses.
module csi2tx_dphy_lp_rx_lane_mon #(
  parameter int NUM_LANES     = 4,
  parameter int FILT_DEPTH    = 2,
  parameter int HS_SETTLE_CYC = 2
) (
  input  logic        txclkesc,
  input  logic        txescclk_rst,
  input  logic        slave,
  input  logic [15:0] cfg_twakeup,
  csi2tx_dphy_lp_rx_lane_mon_if.slave lane_if
);

  typedef enum logic [2:0] {
    ST_STOP,
    ST_HS_RQST,
    ST_HS_ACTIVE,
    ST_ULPS_RQST,
    ST_ULPS,
    ST_ULPS_EXIT,
    ST_ERR
  } lane_state_e;

  localparam logic [7:0] FILT_N   = 8'(FILT_DEPTH);
  localparam logic [3:0] SETTLE_N = 4'(HS_SETTLE_CYC);

  // Leaving the slave role is treated exactly like a reset of every lane.
  logic lane_rst;
  assign lane_rst = txescclk_rst | ~slave;

  assign lane_if.lp_rx_cntrl = {NUM_LANES{slave}};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [1:0]  s1, s2, f, cand;
    logic [7:0]  fcnt;
    lane_state_e state;
    logic        sot_r, err_r;
    logic [3:0]  settle;
    logic [15:0] wake;

    always_ff @(posedge txclkesc) begin
      if (lane_rst) begin
        s1 <= 2'b11;
        s2 <= 2'b11;
      end else begin
        s1 <= {lane_if.lp_rx_cp[g], lane_if.lp_rx_cn[g]};
        s2 <= s1;
      end
    end

    // A new level is accepted only after FILT_DEPTH identical samples in a row.
    always_ff @(posedge txclkesc) begin
      if (lane_rst) begin
        f    <= 2'b11;
        cand <= 2'b11;
        fcnt <= 8'd0;
      end else if (s2 == f) begin
        cand <= f;
        fcnt <= 8'd0;
      end else if ((s2 == cand) && (fcnt != 8'd0)) begin
        if ((fcnt + 8'd1) >= FILT_N) begin
          f    <= s2;
          fcnt <= 8'd0;
        end else begin
          fcnt <= fcnt + 8'd1;
        end
      end else begin
        cand <= s2;
        if (FILT_N <= 8'd1) begin
          f    <= s2;
          fcnt <= 8'd0;
        end else begin
          fcnt <= 8'd1;
        end
      end
    end

    always_ff @(posedge txclkesc) begin
      if (lane_rst) begin
        state  <= ST_STOP;
        sot_r  <= 1'b0;
        err_r  <= 1'b0;
        settle <= 4'd0;
        wake   <= 16'd0;
      end else begin
        sot_r <= 1'b0;
        err_r <= 1'b0;
        if (state == ST_HS_ACTIVE) begin
          if (settle != 4'hF) settle <= settle + 4'd1;
        end else begin
          settle <= 4'd0;
        end

        if (f == 2'b11) begin
          state <= ST_STOP;
          if ((state == ST_ULPS_EXIT) && (wake < cfg_twakeup)) err_r <= 1'b1;
        end else begin
          case (state)
            ST_STOP: begin
              case (f)
                2'b01:   state <= ST_HS_RQST;
                2'b10:   state <= ST_ULPS_RQST;
                default: begin state <= ST_ERR; err_r <= 1'b1; end
              endcase
            end
            ST_HS_RQST: begin
              if (f == 2'b00) begin
                state <= ST_HS_ACTIVE;
                sot_r <= 1'b1;
              end else if (f == 2'b10) begin
                state <= ST_ERR;
                err_r <= 1'b1;
              end
            end
            ST_HS_ACTIVE: begin
              if (f != 2'b00) begin
                state <= ST_ERR;
                err_r <= 1'b1;
              end
            end
            ST_ULPS_RQST: begin
              if (f == 2'b00) begin
                state <= ST_ULPS;
              end else if (f == 2'b01) begin
                state <= ST_ERR;
                err_r <= 1'b1;
              end
            end
            ST_ULPS: begin
              if (f == 2'b10) begin
                state <= ST_ULPS_EXIT;
                wake  <= 16'd0;
              end else if (f == 2'b01) begin
                state <= ST_ERR;
                err_r <= 1'b1;
              end
            end
            ST_ULPS_EXIT: begin
              if (f == 2'b10) begin
                if (wake != 16'hFFFF) wake <= wake + 16'd1;
              end else begin
                state <= ST_ERR;
                err_r <= 1'b1;
              end
            end
            ST_ERR:  state <= ST_ERR;
            default: state <= ST_STOP;
          endcase
        end
      end
    end

    assign lane_if.stopstate[g]     = (state == ST_STOP);
    assign lane_if.rxulpsnot[g]     = (state != ST_ULPS);
    assign lane_if.ulpsactivenot[g] = !((state == ST_ULPS) || (state == ST_ULPS_EXIT));
    assign lane_if.rxactivehs[g]    = (state == ST_HS_ACTIVE);
    assign lane_if.sot[g]           = sot_r;
    assign lane_if.lp_seq_err[g]    = err_r;
    assign lane_if.hs_rx_cntrl[g]   = slave && (state == ST_HS_ACTIVE) && (settle >= SETTLE_N);
  end

endmodule

// File: tb/tb_csi2tx_dphy_lp_rx_lane_mon.sv
// Directed bench for the LP lane monitor: HS entry, ULPS entry/exit, glitches,
// illegal sequences, reset and slave-role drop, all with hand-computed values.
module tb_csi2tx_dphy_lp_rx_lane_mon;
  logic        clk = 1'b0;
  logic        rst;
  logic        slave;
  logic [15:0] cfg_twakeup;
  int          tests_run = 0;
  int          tests_failed = 0;
  int          sot_cnt [4];
  int          err_cnt [4];
  int          act_cnt [4];
  int          s0, e0, a0, e1, e2, e3;

  csi2tx_dphy_lp_rx_lane_mon_if #(.NUM_LANES(4)) bus ();

  csi2tx_dphy_lp_rx_lane_mon dut (
    .txclkesc     (clk),
    .txescclk_rst (rst),
    .slave        (slave),
    .cfg_twakeup  (cfg_twakeup),
    .lane_if      (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 4; i++) begin
      sot_cnt[i] = 0;
      err_cnt[i] = 0;
      act_cnt[i] = 0;
    end
  end

  // Pulse and activity tallies, sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      sot_cnt[i] = sot_cnt[i] + int'(bus.sot[i]);
      err_cnt[i] = err_cnt[i] + int'(bus.lp_seq_err[i]);
      act_cnt[i] = act_cnt[i] + int'(bus.rxactivehs[i]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int lane, input logic [1:0] lines);
    bus.lp_rx_cp[lane] = lines[1];
    bus.lp_rx_cn[lane] = lines[0];
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    slave = 1'b1;
    cfg_twakeup = 16'd16;
    bus.lp_rx_cp = 4'hF;
    bus.lp_rx_cn = 4'hF;
    cyc(3);
    checkOutput("rst_stopstate", 16'(bus.stopstate), 16'hF);
    checkOutput("rst_rxulpsnot", 16'(bus.rxulpsnot), 16'hF);
    checkOutput("rst_ulpsactnot", 16'(bus.ulpsactivenot), 16'hF);
    checkOutput("rst_rxactivehs", 16'(bus.rxactivehs), 16'h0);
    checkOutput("rst_sot", 16'(bus.sot), 16'h0);
    checkOutput("rst_hs_rx_cntrl", 16'(bus.hs_rx_cntrl), 16'h0);
    checkOutput("rst_lp_rx_cntrl", 16'(bus.lp_rx_cntrl), 16'hF);
    checkOutput("rst_lp_seq_err", 16'(bus.lp_seq_err), 16'h0);
    rst = 1'b0;
    cyc(4);

    // Lane 0: HS entry and exit
    s0 = sot_cnt[0]; e0 = err_cnt[0];
    applyStimulus(0, 2'b01);
    cyc(4);
    checkOutput("l0_rqst_latency", 16'(bus.stopstate), 16'hF);
    cyc(1);
    checkOutput("l0_hs_rqst", 16'(bus.stopstate), 16'hE);
    applyStimulus(0, 2'b00);
    a0 = act_cnt[0];
    cyc(4);
    checkOutput("l0_act_latency", 16'(bus.rxactivehs), 16'h0);
    cyc(1);
    checkOutput("l0_rxactivehs", 16'(bus.rxactivehs), 16'h1);
    checkOutput("l0_sot", 16'(bus.sot), 16'h1);
    checkOutput("l0_hs_early0", 16'(bus.hs_rx_cntrl), 16'h0);
    cyc(1);
    checkOutput("l0_sot_end", 16'(bus.sot), 16'h0);
    checkOutput("l0_hs_early1", 16'(bus.hs_rx_cntrl), 16'h0);
    cyc(1);
    checkOutput("l0_hs_settled", 16'(bus.hs_rx_cntrl), 16'h1);
    cyc(13);
    applyStimulus(0, 2'b11);
    cyc(4);
    checkOutput("l0_hs_hold", 16'(bus.hs_rx_cntrl), 16'h1);
    cyc(1);
    checkOutput("l0_stop_back", 16'(bus.stopstate), 16'hF);
    checkOutput("l0_act_off", 16'(bus.rxactivehs), 16'h0);
    checkOutput("l0_hs_off", 16'(bus.hs_rx_cntrl), 16'h0);
    checkOutput("l0_act_cycles", 16'(act_cnt[0] - a0), 16'd20);
    checkOutput("l0_sot_count", 16'(sot_cnt[0] - s0), 16'd1);
    checkOutput("l0_err_count", 16'(err_cnt[0] - e0), 16'd0);

    // Lane 1: clean ULPS exit (40 cycles of Mark-1)
    e1 = err_cnt[1];
    applyStimulus(1, 2'b10);
    cyc(5);
    checkOutput("l1_ulps_rqst", 16'(bus.stopstate), 16'hD);
    checkOutput("l1_rqst_rxulpsnot", 16'(bus.rxulpsnot), 16'hF);
    applyStimulus(1, 2'b00);
    cyc(5);
    checkOutput("l1_ulps_rxulpsnot", 16'(bus.rxulpsnot), 16'hD);
    checkOutput("l1_ulps_actnot", 16'(bus.ulpsactivenot), 16'hD);
    cyc(45);
    applyStimulus(1, 2'b10);
    cyc(5);
    checkOutput("l1_exit_rxulpsnot", 16'(bus.rxulpsnot), 16'hF);
    checkOutput("l1_exit_actnot", 16'(bus.ulpsactivenot), 16'hD);
    cyc(35);
    applyStimulus(1, 2'b11);
    cyc(4);
    checkOutput("l1_exit_hold", 16'(bus.ulpsactivenot), 16'hD);
    cyc(1);
    checkOutput("l1_clean_actnot", 16'(bus.ulpsactivenot), 16'hF);
    checkOutput("l1_clean_stop", 16'(bus.stopstate), 16'hF);
    checkOutput("l1_clean_err", 16'(bus.lp_seq_err), 16'h0);
    cyc(1);
    checkOutput("l1_clean_err_cnt", 16'(err_cnt[1] - e1), 16'd0);

    // Lane 1: short Mark-1 (8 cycles) is a dirty exit
    applyStimulus(1, 2'b10);
    cyc(5);
    applyStimulus(1, 2'b00);
    cyc(5);
    checkOutput("l1b_ulps", 16'(bus.rxulpsnot), 16'hD);
    applyStimulus(1, 2'b10);
    cyc(8);
    applyStimulus(1, 2'b11);
    cyc(4);
    checkOutput("l1b_err_early", 16'(bus.lp_seq_err), 16'h0);
    cyc(1);
    checkOutput("l1b_err_pulse", 16'(bus.lp_seq_err), 16'h2);
    checkOutput("l1b_stop", 16'(bus.stopstate), 16'hF);
    cyc(1);
    checkOutput("l1b_err_end", 16'(bus.lp_seq_err), 16'h0);
    checkOutput("l1b_err_cnt", 16'(err_cnt[1] - e1), 16'd1);

    // Lane 2: one-cycle glitch is filtered
    e2 = err_cnt[2];
    applyStimulus(2, 2'b01);
    cyc(1);
    applyStimulus(2, 2'b11);
    cyc(8);
    checkOutput("l2_glitch_stop", 16'(bus.stopstate), 16'hF);
    checkOutput("l2_glitch_ulps", 16'(bus.rxulpsnot), 16'hF);
    checkOutput("l2_glitch_err", 16'(err_cnt[2] - e2), 16'd0);

    // Lane 3: STOP straight to LP-00 is illegal
    e3 = err_cnt[3];
    applyStimulus(3, 2'b00);
    cyc(4);
    checkOutput("l3_err_early", 16'(bus.lp_seq_err), 16'h0);
    cyc(1);
    checkOutput("l3_err_pulse", 16'(bus.lp_seq_err), 16'h8);
    checkOutput("l3_in_err", 16'(bus.stopstate), 16'h7);
    cyc(1);
    checkOutput("l3_err_end", 16'(bus.lp_seq_err), 16'h0);
    checkOutput("l3_err_stays", 16'(bus.stopstate), 16'h7);
    applyStimulus(3, 2'b11);
    cyc(5);
    checkOutput("l3_stop_back", 16'(bus.stopstate), 16'hF);
    checkOutput("l3_err_cnt", 16'(err_cnt[3] - e3), 16'd1);

    // Concurrent HS on lane 0 and ULPS on lane 3, then reset mid-HS
    applyStimulus(0, 2'b01);
    applyStimulus(3, 2'b10);
    cyc(5);
    checkOutput("cc_rqst_stop", 16'(bus.stopstate), 16'h6);
    applyStimulus(0, 2'b00);
    applyStimulus(3, 2'b00);
    cyc(5);
    checkOutput("cc_act", 16'(bus.rxactivehs), 16'h1);
    checkOutput("cc_ulps", 16'(bus.rxulpsnot), 16'h7);
    checkOutput("cc_ulpsact", 16'(bus.ulpsactivenot), 16'h7);
    checkOutput("cc_sot", 16'(bus.sot), 16'h1);
    cyc(2);
    checkOutput("cc_hs", 16'(bus.hs_rx_cntrl), 16'h1);
    rst = 1'b1;
    cyc(1);
    checkOutput("cc_rst_stop", 16'(bus.stopstate), 16'hF);
    checkOutput("cc_rst_act", 16'(bus.rxactivehs), 16'h0);
    checkOutput("cc_rst_ulps", 16'(bus.rxulpsnot), 16'hF);
    checkOutput("cc_rst_ulpsact", 16'(bus.ulpsactivenot), 16'hF);
    checkOutput("cc_rst_hs", 16'(bus.hs_rx_cntrl), 16'h0);
    cyc(1);
    rst = 1'b0;
    cyc(4);
    checkOutput("cc_post_err_early", 16'(bus.lp_seq_err), 16'h0);
    cyc(1);
    checkOutput("cc_post_err", 16'(bus.lp_seq_err), 16'h9);
    checkOutput("cc_post_state", 16'(bus.stopstate), 16'h6);
    applyStimulus(0, 2'b11);
    applyStimulus(3, 2'b11);
    cyc(6);
    checkOutput("cc_recover", 16'(bus.stopstate), 16'hF);

    // Dropping the slave role during HS_ACTIVE
    applyStimulus(0, 2'b01);
    cyc(5);
    applyStimulus(0, 2'b00);
    cyc(7);
    checkOutput("sl_hs_on", 16'(bus.hs_rx_cntrl), 16'h1);
    slave = 1'b0;
    cyc(1);
    checkOutput("sl_hs_off", 16'(bus.hs_rx_cntrl), 16'h0);
    checkOutput("sl_lp_off", 16'(bus.lp_rx_cntrl), 16'h0);
    checkOutput("sl_stop", 16'(bus.stopstate), 16'hF);
    checkOutput("sl_act", 16'(bus.rxactivehs), 16'h0);
    slave = 1'b1;
    applyStimulus(0, 2'b11);
    cyc(6);
    checkOutput("sl_back_stop", 16'(bus.stopstate), 16'hF);
    checkOutput("sl_back_lp", 16'(bus.lp_rx_cntrl), 16'hF);
    checkOutput("sl_back_err", 16'(bus.lp_seq_err), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
